toy_wb_merge: RTL and testbench
===============================

Name: toy_wb_merge

Overview:
- Writeback collector on the consumer side of the execute-unit result interface.
- Execute units (mext, alu, lsu) emit results with no backpressure (push-only valid). This block buffers them per source and arbitrates round-robin onto a single register-file write port with valid/ready.
- It forwards the instruction index for commit tracking and flushes all buffered results on cancel.

Parameters:
- N_SRC, 2, number of execute-unit result sources
- FIFO_DEPTH, 4, entries per source FIFO (power of 2, >=2)
- PHY_REG_ID_WIDTH, 6, physical register index width
- REG_WIDTH, 32, result data width
- INST_IDX_WIDTH, 8, instruction index width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- src_vld  in  N_SRC  per-source result valid; no ready, push is unconditional
- src_rd_en  in  N_SRC  per-source result writes rd
- src_reg_index  in  N_SRC*PHY_REG_ID_WIDTH  packed per-source physical rd index
- src_reg_val  in  N_SRC*REG_WIDTH  packed per-source result value
- src_inst_idx  in  N_SRC*INST_IDX_WIDTH  packed per-source instruction index
- src_afull  out  N_SRC  per-source almost-full hint for issue throttling
- cancel_en  in  1  pipeline flush
- wb_vld  out  1  writeback entry valid
- wb_rdy  in  1  register file / commit accepts entry
- wb_reg_wr_en  out  1  wb_vld & head rd_en
- wb_reg_index  out  PHY_REG_ID_WIDTH  physical rd index
- wb_reg_val  out  REG_WIDTH  result value
- wb_inst_idx  out  INST_IDX_WIDTH  instruction index for commit
- overflow_err  out  1  sticky: a push was dropped

Behaviour:
Reset and clocking:
- Reset is asynchronous and active-low on rst_n; clock is clk.
- Reset values: all FIFOs empty, rr_ptr=0, grant_lock=0, wb_vld=0, wb_reg_wr_en=0, src_afull=0, overflow_err=0. wb_reg_index/wb_reg_val/wb_inst_idx drive 0 whenever wb_vld=0.

Per-source FIFO:
- Implemented as wr_ptr, rd_ptr, and a count of width clog2(DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- push_i = src_vld[i] & ~cancel_en. pop_i = wb_vld & wb_rdy & (grant==i).
- Push is accepted if count<DEPTH, or if count==DEPTH and pop_i is asserted in the same cycle.
- Otherwise the entry is dropped, count is unchanged, and overflow_err is set (sticky until reset).
- Simultaneous push and pop leaves count unchanged.
- src_afull[i] = count_i >= FIFO_DEPTH-1. This is registered state, not combinational from src_vld.

Latency and visibility:
- An entry pushed in cycle t is visible at the output no earlier than t+1. There is no bypass.

Arbitration:
- Requesters are the non-empty FIFOs.
- Grant goes to the first requester starting at rr_ptr and wrapping upward.
- On a pop from source k, rr_ptr <= (k+1) mod N_SRC.
- Stability: if wb_vld & ~wb_rdy, grant_lock<=1 and locked_src<=grant. While locked, grant=locked_src regardless of new requesters. The lock clears on pop or cancel.
- Fields wb_* must be stable while wb_vld & ~wb_rdy.

Output:
- wb_vld = any requester & ~cancel_en. Fields come combinationally from the granted FIFO head.

Cancel:
- In the cancel cycle: wb_vld=0, no pop, and that cycle's pushes are discarded.
- Next cycle: all counts=0, pointers=0, grant_lock=0. rr_ptr and overflow_err are kept.
- Reset mid-operation clears everything asynchronously; in-flight entries are lost.

Test Plan:
- Single push, src0 {rd_en=1, idx=5, val=0x1234, inst=3} at t, wb_rdy=1 -> wb_vld=1 at t+1 with the same fields, wb_reg_wr_en=1, FIFO empty at t+2.
- Both sources push every cycle for 4 cycles, wb_rdy=1 -> grants alternate src0,src1,src0,...; all 8 entries emerge in per-source order; overflow_err=0.
- wb_rdy=0 for 5 cycles while src0 holds its head, then src1 pushes -> wb_* stay on src0 values for all 5 cycles (lock); src0 pops when wb_rdy rises, then src1.
- src0 pushes 5 entries with wb_rdy=0 -> src_afull[0]=1 after 3rd push; 5th push dropped; overflow_err=1 and stays 1; only 4 entries drain.
- FIFO full, push and pop on the same cycle -> push accepted, count stays 4, overflow_err=0.
- 3 entries buffered, cancel_en=1 with a simultaneous src1 push -> wb_vld=0 that cycle; FIFOs empty next cycle; the cancelled push never appears.

Source files
------------

// File: rtl/toy_wb_merge.sv
// Writeback collector: per-source result FIFOs, round-robin merge onto one RF write port.
// Latency: an entry pushed in cycle t can appear on wb_* at t+1 at the earliest (no bypass).
// Backpressure: sources cannot be stalled; a push into a full FIFO is dropped and flagged in overflow_err.
module toy_wb_merge #(
    parameter int N_SRC            = 2,
    parameter int FIFO_DEPTH       = 4,
    parameter int PHY_REG_ID_WIDTH = 6,
    parameter int REG_WIDTH        = 32,
    parameter int INST_IDX_WIDTH   = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [N_SRC-1:0]                      src_vld,
    input  logic [N_SRC-1:0]                      src_rd_en,
    input  logic [N_SRC*PHY_REG_ID_WIDTH-1:0]     src_reg_index,
    input  logic [N_SRC*REG_WIDTH-1:0]            src_reg_val,
    input  logic [N_SRC*INST_IDX_WIDTH-1:0]       src_inst_idx,
    output logic [N_SRC-1:0]                      src_afull,
    input  logic                                  cancel_en,
    output logic                                  wb_vld,
    input  logic                                  wb_rdy,
    output logic                                  wb_reg_wr_en,
    output logic [PHY_REG_ID_WIDTH-1:0]           wb_reg_index,
    output logic [REG_WIDTH-1:0]                  wb_reg_val,
    output logic [INST_IDX_WIDTH-1:0]             wb_inst_idx,
    output logic                                  overflow_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef struct packed {
        logic                        rd_en;
        logic [PHY_REG_ID_WIDTH-1:0] reg_index;
        logic [REG_WIDTH-1:0]        reg_val;
        logic [INST_IDX_WIDTH-1:0]   inst_idx;
    } ent_t;

    // Storage and per-source FIFO bookkeeping
    ent_t             mem     [N_SRC][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr  [N_SRC];
    logic [PTR_W-1:0] rd_ptr  [N_SRC];
    logic [CNT_W-1:0] count   [N_SRC];
    ent_t             src_ent [N_SRC];

    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] push;
    logic [N_SRC-1:0] push_ok;
    logic [N_SRC-1:0] pop;

    // Arbitration state
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] rr_pick;
    logic [SRC_W-1:0] cand;
    logic [SRC_W-1:0] grant;
    logic [SRC_W-1:0] locked_src;
    logic             grant_lock;
    logic             found;
    int               j;
    ent_t             head;

    // Unpack the flat source buses into one entry per source
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            src_ent[i].rd_en     = src_rd_en[i];
            src_ent[i].reg_index = src_reg_index[i*PHY_REG_ID_WIDTH +: PHY_REG_ID_WIDTH];
            src_ent[i].reg_val   = src_reg_val[i*REG_WIDTH +: REG_WIDTH];
            src_ent[i].inst_idx  = src_inst_idx[i*INST_IDX_WIDTH +: INST_IDX_WIDTH];
        end
    end

    // Requesters are non-empty FIFOs; pushes arriving during a cancel are discarded
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            req[i]       = (count[i] != '0);
            push[i]      = src_vld[i] & ~cancel_en;
            src_afull[i] = (count[i] >= CNT_W'(FIFO_DEPTH - 1));
        end
    end

    // Round-robin search: first requester at or above rr_ptr, wrapping upward
    always_comb begin
        rr_pick = rr_ptr;
        cand    = rr_ptr;
        found   = 1'b0;
        j       = 0;
        for (int off = 0; off < N_SRC; off++) begin
            j = int'(rr_ptr) + off;
            if (j >= N_SRC) begin
                j = j - N_SRC;
            end
            cand = SRC_W'(j);
            if (!found && req[cand]) begin
                found   = 1'b1;
                rr_pick = cand;
            end
        end
    end

    // A stalled grant stays pinned to its source so wb_* cannot change under the consumer
    always_comb begin
        grant = grant_lock ? locked_src : rr_pick;
        head  = mem[grant][rd_ptr[grant]];
    end

    // Output handshake, pop decode and push acceptance (a full FIFO may take a push when it pops)
    always_comb begin
        wb_vld = (|req) & ~cancel_en;
        for (int i = 0; i < N_SRC; i++) begin
            pop[i]     = wb_vld & wb_rdy & (grant == SRC_W'(i));
            push_ok[i] = push[i] & ((count[i] < CNT_W'(FIFO_DEPTH)) | pop[i]);
        end
    end

    // Output fields come straight from the granted head and are zeroed when idle
    always_comb begin
        wb_reg_wr_en = wb_vld & head.rd_en;
        wb_reg_index = wb_vld ? head.reg_index : '0;
        wb_reg_val   = wb_vld ? head.reg_val   : '0;
        wb_inst_idx  = wb_vld ? head.inst_idx  : '0;
    end

    // FIFO pointers and occupancy; cancel empties every FIFO in one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (cancel_en) begin
                    wr_ptr[i] <= '0;
                    rd_ptr[i] <= '0;
                    count[i]  <= '0;
                end else begin
                    if (push_ok[i]) begin
                        wr_ptr[i] <= wr_ptr[i] + 1'b1;
                    end
                    if (pop[i]) begin
                        rd_ptr[i] <= rd_ptr[i] + 1'b1;
                    end
                    case ({push_ok[i], pop[i]})
                        2'b10:   count[i] <= count[i] + 1'b1;
                        2'b01:   count[i] <= count[i] - 1'b1;
                        default: count[i] <= count[i];
                    endcase
                end
            end
        end
    end

    // Entry storage; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (push_ok[i]) begin
                mem[i][wr_ptr[i]] <= src_ent[i];
            end
        end
    end

    // Round-robin pointer advances past the popped source; lock holds a stalled grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            grant_lock <= 1'b0;
            locked_src <= '0;
        end else if (cancel_en) begin
            grant_lock <= 1'b0;
        end else if (|pop) begin
            grant_lock <= 1'b0;
            rr_ptr     <= (grant == SRC_W'(N_SRC - 1)) ? '0 : grant + 1'b1;
        end else if (wb_vld && !wb_rdy) begin
            grant_lock <= 1'b1;
            locked_src <= grant;
        end
    end

    // Sticky flag for any push lost to a full FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_err <= 1'b0;
        end else if (|(push & ~push_ok)) begin
            overflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_toy_wb_merge.sv
// Directed bench for toy_wb_merge with a per-source scoreboard.
// Expected entries are queued when driven; the monitor pops and compares on each wb handshake.
// Source of an output entry is recovered from bit 7 of the instruction index the bench assigns.
module tb_toy_wb_merge;

    typedef struct packed {
        logic        rd_en;
        logic [5:0]  idx;
        logic [31:0] val;
        logic [7:0]  inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v0, v1;
    ent_t        d0, d1;
    logic [1:0]  src_vld;
    logic [1:0]  src_rd_en;
    logic [11:0] src_reg_index;
    logic [63:0] src_reg_val;
    logic [15:0] src_inst_idx;
    logic [1:0]  src_afull;
    logic        cancel_en;
    logic        wb_vld;
    logic        wb_rdy;
    logic        wb_reg_wr_en;
    logic [5:0]  wb_reg_index;
    logic [31:0] wb_reg_val;
    logic [7:0]  wb_inst_idx;
    logic        overflow_err;

    always #5 clk = ~clk;

    assign src_vld       = {v1, v0};
    assign src_rd_en     = {d1.rd_en, d0.rd_en};
    assign src_reg_index = {d1.idx, d0.idx};
    assign src_reg_val   = {d1.val, d0.val};
    assign src_inst_idx  = {d1.inst, d0.inst};

    toy_wb_merge #(
        .N_SRC(2), .FIFO_DEPTH(4), .PHY_REG_ID_WIDTH(6), .REG_WIDTH(32), .INST_IDX_WIDTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .src_vld(src_vld), .src_rd_en(src_rd_en), .src_reg_index(src_reg_index),
        .src_reg_val(src_reg_val), .src_inst_idx(src_inst_idx), .src_afull(src_afull),
        .cancel_en(cancel_en),
        .wb_vld(wb_vld), .wb_rdy(wb_rdy), .wb_reg_wr_en(wb_reg_wr_en),
        .wb_reg_index(wb_reg_index), .wb_reg_val(wb_reg_val), .wb_inst_idx(wb_inst_idx),
        .overflow_err(overflow_err)
    );

    int   total = 0;
    int   bad   = 0;
    ent_t q0[$];
    ent_t q1[$];
    int   pop_log[$];
    ent_t mon_got;
    ent_t mon_exp;
    int   mon_src;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t mk(input logic rd, input logic [5:0] idx,
                                input logic [31:0] val, input logic [7:0] inst);
        ent_t e;
        e.rd_en = rd;
        e.idx   = idx;
        e.val   = val;
        e.inst  = inst;
        return e;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic push0(input ent_t e, input bit keep);
        v0 = 1'b1;
        d0 = e;
        if (keep) q0.push_back(e);
    endtask

    task automatic push1(input ent_t e, input bit keep);
        v1 = 1'b1;
        d1 = e;
        if (keep) q1.push_back(e);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 40; k++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            cyc();
        end
        chk(tag, 64'(q0.size() + q1.size()), 64'd0);
    endtask

    // Scoreboard side: every accepted writeback is matched against its source queue
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wb_vld === 1'b1 && wb_rdy === 1'b1) begin
            mon_got = mk(wb_reg_wr_en, wb_reg_index, wb_reg_val, wb_inst_idx);
            mon_src = wb_inst_idx[7] ? 1 : 0;
            if (mon_src == 0) begin
                chk("pop_pending_src0", 64'(q0.size() != 0), 64'd1);
                if (q0.size() != 0) begin
                    mon_exp = q0.pop_front();
                    chk("entry_src0", 64'(mon_got), 64'(mon_exp));
                end
            end else begin
                chk("pop_pending_src1", 64'(q1.size() != 0), 64'd1);
                if (q1.size() != 0) begin
                    mon_exp = q1.pop_front();
                    chk("entry_src1", 64'(mon_got), 64'(mon_exp));
                end
            end
            pop_log.push_back(mon_src);
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        rst_n     = 1'b0;
        v0        = 1'b0;
        v1        = 1'b0;
        d0        = '0;
        d1        = '0;
        cancel_en = 1'b0;
        wb_rdy    = 1'b1;

        // Reset state
        mid();
        chk("rst_wb_vld", 64'(wb_vld), 64'd0);
        chk("rst_wr_en", 64'(wb_reg_wr_en), 64'd0);
        chk("rst_afull", 64'(src_afull), 64'd0);
        chk("rst_overflow", 64'(overflow_err), 64'd0);
        chk("rst_fields", {26'd0, wb_reg_index, wb_reg_val}, 64'd0);
        chk("rst_inst", 64'(wb_inst_idx), 64'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Both sources push for 4 cycles: grants alternate starting at src0
        pop_log.delete();
        for (int c = 0; c < 4; c++) begin
            push0(mk(1'b1, 6'(c), 32'hA000 + 32'(c), 8'h10 + 8'(c)), 1'b1);
            push1(mk(c[0], 6'(8 + c), 32'hB000 + 32'(c), 8'h90 + 8'(c)), 1'b1);
            cyc();
        end
        v0 = 1'b0;
        v1 = 1'b0;
        drain("drain_alt");
        chk("alt_count", 64'(pop_log.size()), 64'd8);
        for (int k = 0; k < 8 && k < pop_log.size(); k++) begin
            chk($sformatf("alt_grant%0d", k), 64'(pop_log[k]), 64'(k % 2));
        end
        chk("alt_overflow", 64'(overflow_err), 64'd0);

        // Single push: visible one cycle later, then gone
        push0(mk(1'b1, 6'd5, 32'h1234, 8'd3), 1'b1);
        mid();
        chk("single_no_bypass", 64'(wb_vld), 64'd0);
        cyc();
        v0 = 1'b0;
        mid();
        chk("single_vld", 64'(wb_vld), 64'd1);
        chk("single_wr_en", 64'(wb_reg_wr_en), 64'd1);
        chk("single_idx", 64'(wb_reg_index), 64'd5);
        chk("single_val", 64'(wb_reg_val), 64'h1234);
        chk("single_inst", 64'(wb_inst_idx), 64'd3);
        cyc();
        mid();
        chk("single_empty", 64'(wb_vld), 64'd0);
        cyc();

        // Lock: src0 stalled for 5 cycles while src1 arrives behind it
        wb_rdy = 1'b0;
        push0(mk(1'b1, 6'd7, 32'hCAFE, 8'h21), 1'b1);
        cyc();
        v0 = 1'b0;
        push1(mk(1'b1, 6'd9, 32'hBEEF, 8'hA1), 1'b1);
        for (int k = 0; k < 5; k++) begin
            mid();
            chk($sformatf("lock_vld%0d", k), 64'(wb_vld), 64'd1);
            chk($sformatf("lock_inst%0d", k), 64'(wb_inst_idx), 64'h21);
            chk($sformatf("lock_val%0d", k), 64'(wb_reg_val), 64'hCAFE);
            cyc();
            v1 = 1'b0;
        end
        pop_log.delete();
        wb_rdy = 1'b1;
        drain("drain_lock");
        chk("lock_order_n", 64'(pop_log.size()), 64'd2);
        if (pop_log.size() == 2) begin
            chk("lock_order0", 64'(pop_log[0]), 64'd0);
            chk("lock_order1", 64'(pop_log[1]), 64'd1);
        end

        // Full FIFO with push and pop in the same cycle keeps all entries
        wb_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push0(mk(k[0], 6'(10 + k), 32'h5000 + 32'(k), 8'h30 + 8'(k)), 1'b1);
            cyc();
        end
        v0 = 1'b0;
        mid();
        chk("full_afull", 64'(src_afull[0]), 64'd1);
        cyc();
        wb_rdy = 1'b1;
        push0(mk(1'b1, 6'd20, 32'h5555, 8'h3F), 1'b1);
        cyc();
        v0 = 1'b0;
        wb_rdy = 1'b0;
        mid();
        chk("pushpop_overflow", 64'(overflow_err), 64'd0);
        chk("pushpop_afull", 64'(src_afull[0]), 64'd1);
        cyc();
        wb_rdy = 1'b1;
        drain("drain_pushpop");
        chk("pushpop_overflow_end", 64'(overflow_err), 64'd0);

        // Five pushes into a stalled FIFO: afull after the third, fifth dropped
        wb_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push0(mk(1'b1, 6'(40 + k), 32'h6000 + 32'(k), 8'h40 + 8'(k)), k < 4);
            mid();
            chk($sformatf("afull_before_push%0d", k), 64'(src_afull[0]), 64'(k >= 3));
            chk($sformatf("ovf_before_push%0d", k), 64'(overflow_err), 64'd0);
            cyc();
        end
        v0 = 1'b0;
        mid();
        chk("ovf_set", 64'(overflow_err), 64'd1);
        chk("ovf_afull", 64'(src_afull[0]), 64'd1);
        cyc();
        cyc();
        mid();
        chk("ovf_sticky", 64'(overflow_err), 64'd1);
        cyc();
        pop_log.delete();
        wb_rdy = 1'b1;
        drain("drain_ovf");
        cyc();
        cyc();
        chk("ovf_drain_count", 64'(pop_log.size()), 64'd4);
        chk("ovf_sticky_end", 64'(overflow_err), 64'd1);

        // Cancel with three entries buffered and a concurrent src1 push
        wb_rdy = 1'b0;
        push0(mk(1'b1, 6'd50, 32'h7000, 8'h50), 1'b0);
        push1(mk(1'b1, 6'd51, 32'h7001, 8'hD0), 1'b0);
        cyc();
        v1 = 1'b0;
        push0(mk(1'b0, 6'd52, 32'h7002, 8'h51), 1'b0);
        cyc();
        v0 = 1'b0;
        mid();
        chk("pre_cancel_vld", 64'(wb_vld), 64'd1);
        cyc();
        cancel_en = 1'b1;
        wb_rdy    = 1'b1;
        push1(mk(1'b1, 6'd53, 32'h7003, 8'hD1), 1'b0);
        mid();
        chk("cancel_vld", 64'(wb_vld), 64'd0);
        chk("cancel_wr_en", 64'(wb_reg_wr_en), 64'd0);
        cyc();
        cancel_en = 1'b0;
        v1 = 1'b0;
        pop_log.delete();
        for (int k = 0; k < 3; k++) begin
            mid();
            chk($sformatf("post_cancel_vld%0d", k), 64'(wb_vld), 64'd0);
            chk($sformatf("post_cancel_afull%0d", k), 64'(src_afull), 64'd0);
            cyc();
        end
        chk("post_cancel_pops", 64'(pop_log.size()), 64'd0);
        chk("cancel_keeps_ovf", 64'(overflow_err), 64'd1);
        push1(mk(1'b1, 6'd54, 32'h7004, 8'hD2), 1'b1);
        cyc();
        v1 = 1'b0;
        drain("drain_post_cancel");

        // Asynchronous reset in the middle of a cycle with entries in flight
        wb_rdy = 1'b0;
        push0(mk(1'b1, 6'd60, 32'h8000, 8'h60), 1'b0);
        cyc();
        v0 = 1'b0;
        push1(mk(1'b1, 6'd61, 32'h8001, 8'hE0), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", 64'(wb_vld), 64'd0);
        chk("arst_ovf", 64'(overflow_err), 64'd0);
        chk("arst_afull", 64'(src_afull), 64'd0);
        v1 = 1'b0;
        cyc();
        rst_n = 1'b1;
        mid();
        chk("arst_release_vld", 64'(wb_vld), 64'd0);
        cyc();
        push0(mk(1'b1, 6'd62, 32'h8002, 8'h62), 1'b1);
        cyc();
        v0 = 1'b0;
        wb_rdy = 1'b1;
        drain("drain_after_arst");

        chk("left_src0", 64'(q0.size()), 64'd0);
        chk("left_src1", 64'(q1.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
